// File: rtl/key_debounce_if.sv
// Key debounce signal bundle: raw key level in, debounced level/strobe/toggle/count out.
interface key_debounce_if;
  logic       key_in;
  logic       X;
  logic       X_pulse;
  logic       X_tog;
  logic [3:0] press_cnt;

  modport master (
    output key_in,
    input  X,
    input  X_pulse,
    input  X_tog,
    input  press_cnt
  );

  modport slave (
    input  key_in,
    output X,
    output X_pulse,
    output X_tog,
    output press_cnt
  );
endinterface

// File: rtl/key_debounce.sv
// Debounces a raw pushbutton: 2-flop synchronizer plus a 4-state stability FSM.
// Latency: key change settled before edge k appears on X after edge k+2+DB_CYCLES; no backpressure.
module key_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         CLR,
  key_debounce_if.slave kb
);

  localparam int CW = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHK_HI = 2'd1,
    HIGH   = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          s1, s2;
  logic          acc_hi, acc_lo;
  logic          x_q, pulse_q, tog_q;
  logic [3:0]    press_q;

  always_ff @(posedge clk) begin
    if (CLR) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state   <= IDLE;
      cnt     <= '0;
      x_q     <= 1'b0;
      pulse_q <= 1'b0;
      tog_q   <= 1'b0;
      press_q <= 4'd0;
    end else begin
      s1      <= kb.key_in;
      s2      <= s1;
      state   <= state_nx;
      cnt     <= cnt_nx;
      pulse_q <= acc_hi;
      if (acc_hi) begin
        x_q     <= 1'b1;
        tog_q   <= ~tog_q;
        press_q <= press_q + 4'd1;
      end else if (acc_lo) begin
        x_q <= 1'b0;
      end
    end
  end

  // A candidate state only commits after DB_CYCLES consecutive matching samples;
  // any reversion, even on the final count, falls back to the prior stable state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc_hi   = 1'b0;
    acc_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_nx = CHK_HI;
          cnt_nx   = '0;
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          acc_hi   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HIGH: begin
        if (!s2) begin
          state_nx = CHK_LO;
          cnt_nx   = '0;
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_nx = HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          acc_lo   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign kb.X         = x_q;
  assign kb.X_pulse   = pulse_q;
  assign kb.X_tog     = tog_q;
  assign kb.press_cnt = press_q;

endmodule
